arc4_enc: RTL
=============

Name: arc4_enc

Overview:
- ARC4 encryptor: reads a length-prefixed plaintext message from plaintext memory and writes the length-prefixed ciphertext to ciphertext memory. It is the write-side counterpart of the arc4 decryptor.
- Contains the full init / key-schedule / keystream sequencer. The 256-byte state array S lives in an external single-port synchronous RAM driven through the s_* ports.
- Message format, both memories: byte 0 = length L (0..255); bytes 1..L = data.

Parameters:
- none (key width fixed at 24 bits, all addresses 8 bits)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  start request; sampled only while rdy=1
- rdy  output  1  high = idle and able to accept en
- key  input  24  key; key[23:16]=K[0], key[15:8]=K[1], key[7:0]=K[2]; latched on accepted start
- pt_addr  output  8  plaintext RAM read address
- pt_rddata  input  8  plaintext RAM data; valid 1 cycle after pt_addr
- ct_addr  output  8  ciphertext RAM write address
- ct_wrdata  output  8  ciphertext write data
- ct_wren  output  1  ciphertext write strobe, one byte per asserted cycle
- s_addr  output  8  S RAM address
- s_rddata  input  8  S RAM read data; valid 1 cycle after s_addr with s_wren=0
- s_wrdata  output  8  S RAM write data
- s_wren  output  1  S RAM write strobe

Behaviour:
- Reset (async, any state): FSM->IDLE; rdy=1; ct_wren=0; s_wren=0; all addresses and wrdata 0; internal i, j, k, L cleared.
- Reset mid-operation: all of the above takes effect immediately. No further RAM writes occur. Partial ct contents are undefined.
- Handshake: in IDLE with rdy=1, en=1 at a rising edge accepts a start and latches key. rdy is 0 from the next cycle until completion. en while rdy=0 is ignored. rdy returns to 1 in the cycle after the final ct write.
- Back-to-back: en held high through completion starts a new job one cycle after rdy rises.
- INIT: for i=0..255, write S[i]=i, one write per cycle (256 cycles). i wraps 255->0 and ends the phase.
- KSA: j=0. For i=0..255:
  - read S[i]
  - j = (j + S[i] + K[i mod 3]) mod 256
  - read S[j]
  - write S[i]=old S[j], then write S[j]=old S[i]
  - The i=j case must leave S[i] unchanged: the second write carries the value read first.
- All arithmetic is 8-bit and wraps mod 256. i mod 3 comes from a 2-bit counter cycling 0,1,2; no divider.
- READLEN: i=j=0. Read pt[0] into L, then write ct[0]=L.
- PRGA: for k=1..L:
  - i=i+1; read S[i]
  - j=j+S[i]; read S[j]
  - swap S[i] and S[j] as in KSA
  - read S[(S[i]+S[j]) mod 256] (post-swap values) = pad
  - read pt[k]
  - write ct[k] = pt[k] XOR pad
- L=0: only ct[0]=0 is written; return to IDLE after READLEN.
- Write rules:
  - ct_wren and s_wren are each asserted exactly once per intended write.
  - s_wren is never asserted outside INIT/KSA/PRGA.
  - ct_addr never exceeds L.
- Latency: start to rdy=1 is at most 4500 cycles for L=255. Every RAM read waits one cycle before its data is used.

Test Plan:
- Reset: assert rst with en=0 -> rdy=1, ct_wren=0, s_wren=0, all addresses 0; hold 10 cycles, outputs unchanged.
- Known vector: key=24'h4B6579 ("Key"), pt = 09,"Plaintext" -> ct = 09,BB,F3,16,E8,D9,40,AF,0A,D3; rdy high within 4500 cycles; exactly 10 ct writes.
- Round trip: feed the produced ct back as pt with the same key -> output bytes 1..9 equal "Plaintext" (hex 50 6C 61 69 6E 74 65 78 74).
- Zero length: pt[0]=00 -> single write ct[0]=00, rdy returns high, no writes to ct addresses >0.
- Reset mid-KSA: assert rst ~300 cycles after start -> rdy=1 and s_wren=0 in the same cycle; a subsequent start with key 4B6579 still yields the known-vector ct.
- Busy/back-to-back: toggle en during the job -> no effect, ct identical; en held high -> second job starts one cycle after rdy rises, and the ct memory model shows identical results.

Source files
------------

// File: rtl/arc4_enc.sv
// ARC4 encryptor: length-prefixed plaintext in, length-prefixed ciphertext out.
// The S array lives in an external single-port synchronous RAM behind the s_* ports.
module arc4_enc (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    typedef enum logic [3:0] {
        StIdle, StInit, StRdI, StGetI, StRdJ, StGetJ, StWrI, StWrJ,
        StLenRd, StLenGet, StLenWr, StRdPad, StGetPad, StWrCt
    } state_e;

    state_e      state_q;
    logic [23:0] key_q;
    logic [7:0]  i_q, j_q, k_q, len_q, si_q, sj_q;
    logic [1:0]  kidx_q;
    logic        prga_q;
    logic [7:0]  k_byte;
    logic [7:0]  j_d;

    always_comb begin
        k_byte = key_q[7:0];
        unique case (kidx_q)
            2'd0:    k_byte = key_q[23:16];
            2'd1:    k_byte = key_q[15:8];
            default: k_byte = key_q[7:0];
        endcase
    end

    // The key byte only enters j during the key schedule.
    assign j_d = j_q + s_rddata + (prga_q ? 8'd0 : k_byte);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rdy       <= 1'b1;
            key_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            len_q     <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            kidx_q    <= '0;
            prga_q    <= 1'b0;
            pt_addr   <= '0;
            ct_addr   <= '0;
            ct_wrdata <= '0;
            ct_wren   <= 1'b0;
            s_addr    <= '0;
            s_wrdata  <= '0;
            s_wren    <= 1'b0;
        end else begin
            ct_wren <= 1'b0;
            s_wren  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en) begin
                        key_q    <= key;
                        rdy      <= 1'b0;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                        len_q    <= '0;
                        prga_q   <= 1'b0;
                        s_addr   <= '0;
                        s_wrdata <= '0;
                        s_wren   <= 1'b1;
                        state_q  <= StInit;
                    end
                end
                StInit: begin
                    if (i_q == 8'hff) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        kidx_q  <= '0;
                        s_addr  <= '0;
                        state_q <= StRdI;
                    end else begin
                        i_q      <= i_q + 8'd1;
                        s_addr   <= i_q + 8'd1;
                        s_wrdata <= i_q + 8'd1;
                        s_wren   <= 1'b1;
                    end
                end
                StRdI: state_q <= StGetI;
                StGetI: begin
                    si_q    <= s_rddata;
                    j_q     <= j_d;
                    s_addr  <= j_d;
                    state_q <= StRdJ;
                end
                StRdJ: state_q <= StGetJ;
                StGetJ: begin
                    sj_q     <= s_rddata;
                    s_addr   <= i_q;
                    s_wrdata <= s_rddata;
                    s_wren   <= 1'b1;
                    state_q  <= StWrI;
                end
                // Second write carries the first-read value, so i == j leaves S[i] intact.
                StWrI: begin
                    s_addr   <= j_q;
                    s_wrdata <= si_q;
                    s_wren   <= 1'b1;
                    state_q  <= StWrJ;
                end
                StWrJ: begin
                    if (prga_q) begin
                        s_addr  <= si_q + sj_q;
                        pt_addr <= k_q;
                        state_q <= StRdPad;
                    end else if (i_q == 8'hff) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        pt_addr <= '0;
                        state_q <= StLenRd;
                    end else begin
                        i_q     <= i_q + 8'd1;
                        s_addr  <= i_q + 8'd1;
                        kidx_q  <= (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                        state_q <= StRdI;
                    end
                end
                StLenRd: state_q <= StLenGet;
                StLenGet: begin
                    len_q     <= pt_rddata;
                    ct_addr   <= '0;
                    ct_wrdata <= pt_rddata;
                    ct_wren   <= 1'b1;
                    state_q   <= StLenWr;
                end
                StLenWr: begin
                    if (len_q == 8'd0) begin
                        rdy     <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        k_q     <= 8'd1;
                        i_q     <= 8'd1;
                        s_addr  <= 8'd1;
                        prga_q  <= 1'b1;
                        state_q <= StRdI;
                    end
                end
                StRdPad: state_q <= StGetPad;
                StGetPad: begin
                    ct_addr   <= k_q;
                    ct_wrdata <= pt_rddata ^ s_rddata;
                    ct_wren   <= 1'b1;
                    state_q   <= StWrCt;
                end
                StWrCt: begin
                    if (k_q == len_q) begin
                        rdy     <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        k_q     <= k_q + 8'd1;
                        i_q     <= i_q + 8'd1;
                        s_addr  <= i_q + 8'd1;
                        state_q <= StRdI;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
